sha256_padder: RTL and testbench
================================

// Module: sha256_padder
// PURPOSE
//  Upstream stage of the sha256 core: turns a byte-aligned message word stream into padded 512-bit blocks.
//  Appends the 0x80 marker, zero fill and the 64-bit big-endian bit length per FIPS 180-4.
//  Emits blocks on a valid/ready handshake. Flags the first and last block of each message so the core can reload INIT_HASH.
// PARAMETERS
//  LEN_W  64  bit-length counter width; length wraps modulo 2^LEN_W, and only the low 64 bits are emitted.
// PORTS
//  clk_i        in   1    clock
//  rst_i        in   1    reset, synchronous, active-high
//  data_i       in   32   message word; first message byte in [31:24]
//  bytes_i      in   3    valid bytes in data_i on last_i beat (0..4, MSB-aligned); ignored (=4) when !last_i
//  last_i       in   1    final word of message
//  vld_i        in   1    input word valid
//  rdy_o        out  1    input ready; transfer on vld_i & rdy_o
//  blk_o        out  512  padded block; blk_o[32*i+:32] = W_i (core word order)
//  blk_vld_o    out  1    block valid; held with blk_o stable until blk_rdy_i
//  blk_rdy_i    in   1    downstream ready (core IDLE/DONE)
//  blk_first_o  out  1    blk_o is first block of a message
//  blk_last_o   out  1    blk_o is final block of a message
// BEHAVIOUR
//  Reset: state COLLECT, wcnt=0, len=0, first=1; rdy_o=1, blk_vld_o=0, blk_o=0, blk_first_o=0, blk_last_o=0.
//  Reset mid-message discards the partial block and the pending length. Reset wins over any simultaneous handshake.
//  COLLECT (rdy_o=1): accepted word goes to W[wcnt]; len += 32, or 8*bytes_i on last; wcnt++.
//   - !last, wcnt==15: block full -> SEND, fin=0.
//   - last: r = 4*wcnt+bytes_i bytes in block (bytes_i>4 treated as 4); mask unused bytes to 0.
//     Insert 0x80 at byte r, zero bytes r+1..63.
//     r<=55: W14/W15 = len[63:32]/len[31:0] (len includes this beat) -> SEND, fin=1.
//     56<=r<=63: -> SEND, fin=0, pend=EXTRA_Z (zeros+len).
//     r==64: -> SEND, fin=0, pend=EXTRA_M (0x80000000 in W0, zeros, len).
//  SEND (rdy_o=0, blk_vld_o=1): on blk_rdy_i:
//   - pend set: rebuild blk_o on the same edge, stay SEND with fin=1, first=0; clear pend.
//   - else: -> COLLECT, wcnt=0. If fin: len=0 and first=1; otherwise first=0.
//  blk_first_o = first flag; blk_last_o = fin; both are valid only while blk_vld_o=1.
//  Latency: blk_vld_o rises the cycle after the accepting beat (16th word or last). The extra block is valid the cycle after the preceding block handshake.
//  No input bubble is required beyond the SEND cycles. An input is never accepted in the same cycle as a block handshake.
//  Empty message: last_i with bytes_i=0 at wcnt=0 gives a single block.
//  Overlong message: len wraps silently.
// STRUCTURE
//  Add to sha256_pkg: padder state enum (COLLECT, SEND) and BLK_W=512 constant.
//  Add a function pad_word(data, nbytes, mark) to sha256_pkg; it returns the masked word with the 0x80 marker.
//  Single module, no sub-module. Registers: 16x32 word buffer, 4-bit wcnt, LEN_W len, fin/first/pend flags.
//  Expected size ~200 lines.
// TESTING
//  "abc": data_i=32'h61626300, bytes_i=3, last -> one block: W0=32'h61626380, W1..W14=0, W15=32'h18; first=last=1.
//  Empty: bytes_i=0, last -> W0=32'h80000000, others 0; first=last=1.
//  56-byte msg (14 full words, bytes_i=4) -> blk1: W14=32'h80000000, W15=0, last=0. blk2: W0..W14=0, W15=32'h1C0, first=0, last=1.
//  64-byte msg -> blk1 data only, last=0. blk2: W0=32'h80000000, W15=32'h200, last=1. Chain into sha256 and compare the digest with the golden model.
//  Backpressure: blk_rdy_i low 10 cycles -> blk_o/blk_vld_o stable, rdy_o=0, no input accepted. Then two back-to-back messages: len resets and first=1 on message 2.
//  rst_i pulsed after 7 words -> outputs at reset values. Next "abc" message yields W15=32'h18.

Source files
------------

// File: rtl/sha256_padder_pkg.sv
// Shared types and helpers for the SHA-256 message padder.
package sha256_padder_pkg;

    localparam int BLK_W = 512;
    localparam int WORDS = 16;

    typedef enum logic {
        COLLECT,
        SEND
    } padder_state_e;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_Z,
        PEND_M
    } pend_e;

    // Keeps the first nbytes bytes (MSB-first); 0x80 lands on byte nbytes when mark is set.
    function automatic logic [31:0] pad_word(input logic [31:0] data,
                                             input logic [2:0]  nbytes,
                                             input logic        mark);
        logic [31:0] w;
        w = data;
        for (int b = 0; b < 4; b++) begin
            if (b >= int'(nbytes)) begin
                w[31-8*b -: 8] = (mark && b == int'(nbytes)) ? 8'h80 : 8'h00;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sha256_padder_if.sv
// Word-stream input and padded-block output of the SHA-256 padder.
interface sha256_padder_if;
    import sha256_padder_pkg::*;

    logic [31:0]      data_i;
    logic [2:0]       bytes_i;
    logic             last_i;
    logic             vld_i;
    logic             rdy_o;
    logic [BLK_W-1:0] blk_o;
    logic             blk_vld_o;
    logic             blk_rdy_i;
    logic             blk_first_o;
    logic             blk_last_o;

    modport slave (
        input  data_i, bytes_i, last_i, vld_i, blk_rdy_i,
        output rdy_o, blk_o, blk_vld_o, blk_first_o, blk_last_o
    );

    modport master (
        output data_i, bytes_i, last_i, vld_i, blk_rdy_i,
        input  rdy_o, blk_o, blk_vld_o, blk_first_o, blk_last_o
    );

endinterface

// File: rtl/sha256_padder.sv
// Packs a byte-aligned word stream into FIPS 180-4 padded 512-bit blocks.
//   state   | meaning
//   COLLECT | accepting message words into the block buffer
//   SEND    | block presented downstream; an extra length block may follow
module sha256_padder
    import sha256_padder_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input logic            clk_i,
    input logic            rst_i,
    sha256_padder_if.slave bus
);

    padder_state_e    state;
    logic [31:0]      wbuf [WORDS];
    logic [3:0]       wcnt;
    logic [LEN_W-1:0] len;
    logic             fin;
    logic             first;
    pend_e            pend;

    logic [2:0]       nb;
    logic [6:0]       r;
    logic [LEN_W-1:0] len_nxt;
    logic [63:0]      len64_nxt;
    logic [63:0]      len64;
    logic [31:0]      w_fill  [WORDS];
    logic [31:0]      w_extra [WORDS];

    always_comb begin
        nb        = (bus.bytes_i > 3'd4) ? 3'd4 : bus.bytes_i;
        r         = 7'({wcnt, 2'b00}) + 7'(nb);
        len_nxt   = len + (bus.last_i ? LEN_W'({nb, 3'b000}) : LEN_W'(32));
        len64_nxt = 64'(len_nxt);
        len64     = 64'(len);
        for (int i = 0; i < WORDS; i++) begin
            if (i < int'(wcnt)) begin
                w_fill[i] = wbuf[i];
            end else if (i == int'(wcnt)) begin
                w_fill[i] = pad_word(bus.data_i, nb, 1'b1);
            end else if (i == int'(wcnt) + 1 && nb == 3'd4) begin
                w_fill[i] = 32'h8000_0000;
            end else begin
                w_fill[i] = '0;
            end
            w_extra[i] = '0;
        end
        // Length fits in this block only when at least 8 bytes remain after the marker.
        if (r <= 7'd55) begin
            w_fill[14] = len64_nxt[63:32];
            w_fill[15] = len64_nxt[31:0];
        end
        w_extra[0]  = (pend == PEND_M) ? 32'h8000_0000 : 32'h0;
        w_extra[14] = len64[63:32];
        w_extra[15] = len64[31:0];
    end

    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            bus.blk_o[32*i +: 32] = wbuf[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= COLLECT;
            wcnt            <= '0;
            len             <= '0;
            fin             <= 1'b0;
            first           <= 1'b1;
            pend            <= PEND_NONE;
            for (int i = 0; i < WORDS; i++) begin
                wbuf[i] <= '0;
            end
            bus.rdy_o       <= 1'b1;
            bus.blk_vld_o   <= 1'b0;
            bus.blk_first_o <= 1'b0;
            bus.blk_last_o  <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (bus.vld_i) begin
                        len <= len_nxt;
                        if (bus.last_i) begin
                            for (int i = 0; i < WORDS; i++) begin
                                wbuf[i] <= w_fill[i];
                            end
                            fin             <= (r <= 7'd55);
                            pend            <= (r <= 7'd55) ? PEND_NONE :
                                               ((r == 7'd64) ? PEND_M : PEND_Z);
                            state           <= SEND;
                            bus.rdy_o       <= 1'b0;
                            bus.blk_vld_o   <= 1'b1;
                            bus.blk_first_o <= first;
                            bus.blk_last_o  <= (r <= 7'd55);
                        end else begin
                            wbuf[wcnt] <= bus.data_i;
                            wcnt       <= wcnt + 4'd1;
                            if (wcnt == 4'd15) begin
                                fin             <= 1'b0;
                                state           <= SEND;
                                bus.rdy_o       <= 1'b0;
                                bus.blk_vld_o   <= 1'b1;
                                bus.blk_first_o <= first;
                                bus.blk_last_o  <= 1'b0;
                            end
                        end
                    end
                end
                SEND: begin
                    if (bus.blk_rdy_i) begin
                        if (pend != PEND_NONE) begin
                            for (int i = 0; i < WORDS; i++) begin
                                wbuf[i] <= w_extra[i];
                            end
                            fin             <= 1'b1;
                            first           <= 1'b0;
                            pend            <= PEND_NONE;
                            bus.blk_first_o <= 1'b0;
                            bus.blk_last_o  <= 1'b1;
                        end else begin
                            state           <= COLLECT;
                            wcnt            <= '0;
                            bus.rdy_o       <= 1'b1;
                            bus.blk_vld_o   <= 1'b0;
                            bus.blk_first_o <= 1'b0;
                            bus.blk_last_o  <= 1'b0;
                            if (fin) begin
                                len   <= '0;
                                first <= 1'b1;
                            end else begin
                                first <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: byte-level FIPS padding model plus literal block checks.
module tb_sha256_padder;
    import sha256_padder_pkg::*;

    typedef logic [7:0] byte_t;
    typedef struct {
        logic [BLK_W-1:0] blk;
        logic             first;
        logic             last;
    } blk_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    sha256_padder_if bus();

    sha256_padder #(.LEN_W(64)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int   n_cmp   = 0;
    int   n_mis   = 0;
    int   acc_cnt = 0;
    blk_t exp_q[$];
    blk_t cap[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input logic [BLK_W-1:0] act,
                           input logic [BLK_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Whole-message padding at byte level, then split into 64-byte blocks.
    function automatic void model_push(input byte_t m[$]);
        byte_t       q[$];
        logic [63:0] bl;
        blk_t        e;
        int          nblk;
        q = m;
        q.push_back(8'h80);
        while (q.size() % 64 != 56) q.push_back(8'h00);
        bl = 64'(m.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) q.push_back(bl[8*k +: 8]);
        nblk = q.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.blk = '0;
            for (int w = 0; w < 16; w++) begin
                e.blk[32*w +: 32] = {q[64*b+4*w], q[64*b+4*w+1], q[64*b+4*w+2], q[64*b+4*w+3]};
            end
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endfunction

    function automatic logic [31:0] cw(input int idx, input int w);
        if (idx >= cap.size()) return 32'hDEAD_BEEF;
        return cap[idx].blk[32*w +: 32];
    endfunction

    function automatic logic [31:0] cflag(input int idx, input bit want_last);
        if (idx >= cap.size()) return 32'hDEAD_BEEF;
        return want_last ? 32'(cap[idx].last) : 32'(cap[idx].first);
    endfunction

    always @(negedge clk_i) begin
        if (!rst_i && bus.blk_vld_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_block: got blk_vld_o=1 want no block");
            end else begin
                chk_blk("blk_o", bus.blk_o, exp_q[0].blk);
                chk("blk_first_o", 32'(bus.blk_first_o), 32'(exp_q[0].first));
                chk("blk_last_o", 32'(bus.blk_last_o), 32'(exp_q[0].last));
            end
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i) begin
            if (bus.vld_i && bus.rdy_o) acc_cnt++;
            if (bus.blk_vld_o && bus.blk_rdy_i) begin
                blk_t c;
                c.blk   = bus.blk_o;
                c.first = bus.blk_first_o;
                c.last  = bus.blk_last_o;
                cap.push_back(c);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send_msg(input byte_t m[$], input bit over);
        int nw;
        int t;
        model_push(m);
        nw = (m.size() == 0) ? 1 : (m.size() + 3) / 4;
        for (int j = 0; j < nw; j++) begin
            logic [31:0] d;
            int          nb;
            nb = m.size() - 4 * j;
            if (nb > 4) nb = 4;
            for (int k = 0; k < 4; k++) begin
                if (k < nb) d[31-8*k -: 8] = m[4*j+k];
                else        d[31-8*k -: 8] = 8'hA5;
            end
            @(negedge clk_i);
            bus.data_i  = d;
            bus.last_i  = (j == nw - 1);
            bus.bytes_i = (j == nw - 1) ? ((over && nb == 4) ? 3'd6 : 3'(nb)) : 3'd1;
            bus.vld_i   = 1'b1;
            t = 0;
            while (bus.rdy_o !== 1'b1 && t < 200) begin
                @(negedge clk_i);
                t++;
            end
            if (t >= 200) begin
                n_cmp++;
                n_mis++;
                $display("FAIL rdy_timeout: got rdy_o=0 for 200 cycles want 1");
            end
            @(posedge clk_i);
        end
    endtask

    task automatic drop();
        @(negedge clk_i);
        bus.vld_i  = 1'b0;
        bus.last_i = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.blk_vld_o === 1'b1) && t < 500) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 500) begin
            n_cmp++;
            n_mis++;
            $display("FAIL drain_timeout: got %0d blocks pending want 0", exp_q.size());
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy_o"}, 32'(bus.rdy_o), 32'd1);
        chk({tag, "_blk_vld_o"}, 32'(bus.blk_vld_o), 32'd0);
        chk_blk({tag, "_blk_o"}, bus.blk_o, '0);
        chk({tag, "_blk_first_o"}, 32'(bus.blk_first_o), 32'd0);
        chk({tag, "_blk_last_o"}, 32'(bus.blk_last_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_t m[$];
        byte_t m2[$];
        int    base;
        int    snap;
        int    lens[15] = '{1, 4, 5, 52, 55, 57, 59, 60, 61, 63, 65, 100, 119, 120, 128};

        bus.data_i    = '0;
        bus.bytes_i   = '0;
        bus.last_i    = 1'b0;
        bus.vld_i     = 1'b0;
        bus.blk_rdy_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        chk_reset_outputs("reset");

        // "abc"
        base = cap.size();
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        drop();
        chk("abc_latency", 32'(bus.blk_vld_o), 32'd1);
        wait_drain();
        chk("abc_w0", cw(base, 0), 32'h6162_6380);
        chk("abc_w1", cw(base, 1), 32'h0);
        chk("abc_w15", cw(base, 15), 32'h18);
        chk("abc_first", cflag(base, 0), 32'd1);
        chk("abc_last", cflag(base, 1), 32'd1);

        // empty
        base = cap.size();
        m.delete();
        send_msg(m, 1'b0);
        drop();
        wait_drain();
        chk("empty_w0", cw(base, 0), 32'h8000_0000);
        chk("empty_w15", cw(base, 15), 32'h0);
        chk("empty_last", cflag(base, 1), 32'd1);

        // 56 bytes: marker in W14, length spills into a second block
        base = cap.size();
        m.delete();
        for (int i = 0; i < 56; i++) m.push_back(8'(i + 1));
        send_msg(m, 1'b0);
        drop();
        wait_drain();
        chk("m56_b1_w14", cw(base, 14), 32'h8000_0000);
        chk("m56_b1_w15", cw(base, 15), 32'h0);
        chk("m56_b1_last", cflag(base, 1), 32'd0);
        chk("m56_b2_w0", cw(base + 1, 0), 32'h0);
        chk("m56_b2_w15", cw(base + 1, 15), 32'h1C0);
        chk("m56_b2_first", cflag(base + 1, 0), 32'd0);
        chk("m56_b2_last", cflag(base + 1, 1), 32'd1);

        // 64 bytes, final bytes_i above 4
        base = cap.size();
        m.delete();
        for (int i = 0; i < 64; i++) m.push_back(8'(i * 3 + 7));
        send_msg(m, 1'b1);
        drop();
        wait_drain();
        chk("m64_b1_w15", cw(base, 15), {m[60], m[61], m[62], m[63]});
        chk("m64_b1_last", cflag(base, 1), 32'd0);
        chk("m64_b2_w0", cw(base + 1, 0), 32'h8000_0000);
        chk("m64_b2_w15", cw(base + 1, 15), 32'h200);
        chk("m64_b2_last", cflag(base + 1, 1), 32'd1);

        foreach (lens[n]) begin
            m.delete();
            for (int i = 0; i < lens[n]; i++) m.push_back(8'(i * 37 + lens[n]));
            send_msg(m, lens[n] % 2 == 1);
            drop();
            wait_drain();
        end

        // backpressure, then two back-to-back messages
        base = cap.size();
        @(negedge clk_i);
        bus.blk_rdy_i = 1'b0;
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        @(negedge clk_i);
        bus.data_i  = 32'h1122_3344;
        bus.bytes_i = 3'd4;
        bus.last_i  = 1'b0;
        bus.vld_i   = 1'b1;
        snap = acc_cnt;
        repeat (10) begin
            @(negedge clk_i);
            chk("bp_rdy_o", 32'(bus.rdy_o), 32'd0);
            chk("bp_blk_vld_o", 32'(bus.blk_vld_o), 32'd1);
        end
        chk("bp_no_accept", 32'(acc_cnt), 32'(snap));
        bus.vld_i     = 1'b0;
        bus.blk_rdy_i = 1'b1;
        m.delete();
        for (int i = 0; i < 20; i++) m.push_back(8'(8'hC0 + i));
        m2 = '{8'h78, 8'h79, 8'h7A};
        send_msg(m, 1'b0);
        send_msg(m2, 1'b0);
        drop();
        wait_drain();
        chk("b2b_a_w15", cw(base + 1, 15), 32'hA0);
        chk("b2b_a_first", cflag(base + 1, 0), 32'd1);
        chk("b2b_b_w15", cw(base + 2, 15), 32'h18);
        chk("b2b_b_first", cflag(base + 2, 0), 32'd1);

        // reset mid-message, with a last beat presented during reset
        for (int j = 0; j < 7; j++) begin
            @(negedge clk_i);
            bus.data_i  = 32'(j + 1) * 32'h0101_0101;
            bus.bytes_i = 3'd4;
            bus.last_i  = 1'b0;
            bus.vld_i   = 1'b1;
            @(posedge clk_i);
        end
        @(negedge clk_i);
        rst_i       = 1'b1;
        bus.last_i  = 1'b1;
        bus.bytes_i = 3'd3;
        @(negedge clk_i);
        rst_i      = 1'b0;
        bus.vld_i  = 1'b0;
        bus.last_i = 1'b0;
        chk_reset_outputs("midrst");
        base = cap.size();
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m, 1'b0);
        drop();
        wait_drain();
        chk("rst_abc_w0", cw(base, 0), 32'h6162_6380);
        chk("rst_abc_w15", cw(base, 15), 32'h18);
        chk("rst_abc_first", cflag(base, 0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
